// File: rtl/morra_cinese_param_if.sv
// Bus between the player input encoders and the morra cinese game engine.
// The master drives the moves and setup request; the slave returns results and scores.
interface morra_cinese_param_if #(
    parameter int CNT_W = 5
);
    logic             INIZIO;
    logic [1:0]       PRIMO;
    logic [1:0]       SECONDO;
    logic [1:0]       MANCHE;
    logic [1:0]       PARTITA;
    logic [CNT_W-1:0] PUNTI_PRIMO;
    logic [CNT_W-1:0] PUNTI_SECONDO;
    logic [CNT_W-1:0] MANCHE_GIOCATE;

    modport master (
        output INIZIO, PRIMO, SECONDO,
        input  MANCHE, PARTITA, PUNTI_PRIMO, PUNTI_SECONDO, MANCHE_GIOCATE
    );

    modport slave (
        input  INIZIO, PRIMO, SECONDO,
        output MANCHE, PARTITA, PUNTI_PRIMO, PUNTI_SECONDO, MANCHE_GIOCATE
    );
endinterface

// File: rtl/morra_cinese_param.sv
// Rock-paper-scissors match engine: one manche per clock, configurable match length,
// lead-margin early finish and optional ban on repeating the previous winning move.
module morra_cinese_param #(
    parameter int MIN_MANCHE = 4,
    parameter int VANTAGGIO  = 2,
    parameter int CNT_W      = 5,
    parameter bit REGOLA_RIP = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    morra_cinese_param_if.slave    bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, GIOCO = 2'd1, FINE = 2'd2} state_t;

    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_MANCHE);
    localparam logic [CNT_W-1:0] VANT_C = CNT_W'(VANTAGGIO);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] pp_q, pp_d;
    logic [CNT_W-1:0] ps_q, ps_d;
    logic [CNT_W-1:0] mg_q, mg_d;
    logic [1:0]       manche_q, manche_d;
    logic [1:0]       partita_q, partita_d;
    logic [1:0]       rec_who_q, rec_who_d;   // 00 none, 01 primo, 10 secondo
    logic [1:0]       rec_move_q, rec_move_d;

    logic             mosse_ok;
    logic             primo_vince;
    logic             pareggio;
    logic             bloccata;
    logic [CNT_W-1:0] scarto;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            max_q      <= MIN_C;
            pp_q       <= '0;
            ps_q       <= '0;
            mg_q       <= '0;
            manche_q   <= 2'b00;
            partita_q  <= 2'b00;
            rec_who_q  <= 2'b00;
            rec_move_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            max_q      <= max_d;
            pp_q       <= pp_d;
            ps_q       <= ps_d;
            mg_q       <= mg_d;
            manche_q   <= manche_d;
            partita_q  <= partita_d;
            rec_who_q  <= rec_who_d;
            rec_move_q <= rec_move_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        max_d      = max_q;
        pp_d       = pp_q;
        ps_d       = ps_q;
        mg_d       = mg_q;
        manche_d   = 2'b00;
        partita_d  = partita_q;
        rec_who_d  = rec_who_q;
        rec_move_d = rec_move_q;

        mosse_ok    = (bus.PRIMO != 2'b00) && (bus.SECONDO != 2'b00);
        pareggio    = (bus.PRIMO == bus.SECONDO);
        primo_vince = ((bus.PRIMO == 2'b01) && (bus.SECONDO == 2'b11)) ||
                      ((bus.PRIMO == 2'b10) && (bus.SECONDO == 2'b01)) ||
                      ((bus.PRIMO == 2'b11) && (bus.SECONDO == 2'b10));
        bloccata    = REGOLA_RIP &&
                      (((rec_who_q == 2'b01) && (bus.PRIMO   == rec_move_q)) ||
                       ((rec_who_q == 2'b10) && (bus.SECONDO == rec_move_q)));
        scarto      = '0;

        if (bus.INIZIO) begin
            // Setup wins over any moves presented on the same cycle.
            max_d      = {{(CNT_W-4){1'b0}}, bus.SECONDO, bus.PRIMO} + MIN_C;
            pp_d       = '0;
            ps_d       = '0;
            mg_d       = '0;
            partita_d  = 2'b00;
            rec_who_d  = 2'b00;
            rec_move_d = 2'b00;
            state_d    = GIOCO;
        end else if (state_q == GIOCO && mosse_ok && !bloccata) begin
            mg_d = mg_q + 1'b1;
            if (pareggio) begin
                manche_d  = 2'b11;
                rec_who_d = 2'b00;
                rec_move_d = 2'b00;
            end else if (primo_vince) begin
                manche_d   = 2'b01;
                pp_d       = pp_q + 1'b1;
                rec_who_d  = 2'b01;
                rec_move_d = bus.PRIMO;
            end else begin
                manche_d   = 2'b10;
                ps_d       = ps_q + 1'b1;
                rec_who_d  = 2'b10;
                rec_move_d = bus.SECONDO;
            end

            scarto = (pp_d >= ps_d) ? (pp_d - ps_d) : (ps_d - pp_d);
            if ((mg_d == max_q) || ((mg_d >= MIN_C) && (scarto >= VANT_C))) begin
                state_d = FINE;
                if (pp_d > ps_d)      partita_d = 2'b01;
                else if (pp_d < ps_d) partita_d = 2'b10;
                else                  partita_d = 2'b11;
            end
        end
    end

    always_comb begin
        bus.MANCHE         = manche_q;
        bus.PARTITA        = partita_q;
        bus.PUNTI_PRIMO    = pp_q;
        bus.PUNTI_SECONDO  = ps_q;
        bus.MANCHE_GIOCATE = mg_q;
    end
endmodule

// File: tb/tb_morra_cinese_param.sv
// Scoreboard bench: two engines (repeat rule on / off) driven with the same moves,
// each checked every cycle against an arithmetic model of the game rules.
module tb_morra_cinese_param;
    localparam int MIN_M = 4;
    localparam int VANT  = 2;
    localparam int W     = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    morra_cinese_param_if #(.CNT_W(W)) bus0 ();
    morra_cinese_param_if #(.CNT_W(W)) bus1 ();

    morra_cinese_param #(.MIN_MANCHE(MIN_M), .VANTAGGIO(VANT), .CNT_W(W), .REGOLA_RIP(1'b1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    morra_cinese_param #(.MIN_MANCHE(MIN_M), .VANTAGGIO(VANT), .CNT_W(W), .REGOLA_RIP(1'b0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    typedef struct {
        int manche;
        int partita;
        int pp;
        int ps;
        int mg;
    } snap_t;

    snap_t q0[$];
    snap_t q1[$];
    int checks = 0;
    int failures = 0;

    // Model state per engine: phase 0 idle, 1 playing, 2 finished
    int m_phase[2], m_max[2], m_pp[2], m_ps[2], m_mg[2];
    int m_manche[2], m_partita[2], m_lw[2], m_lm[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_max[k] = MIN_M; m_pp[k] = 0; m_ps[k] = 0; m_mg[k] = 0;
            m_manche[k] = 0; m_partita[k] = 0; m_lw[k] = 0; m_lm[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit ini, input int p, input int s);
        int res;
        bit blocked;
        int lead;
        m_manche[k] = 0;
        if (ini) begin
            m_max[k] = s * 4 + p + MIN_M;
            m_pp[k] = 0; m_ps[k] = 0; m_mg[k] = 0; m_lw[k] = 0; m_lm[k] = 0;
            m_partita[k] = 0;
            m_phase[k] = 1;
        end else if (m_phase[k] == 1 && p != 0 && s != 0) begin
            if (p == s)                    res = 3;
            else if ((p - s + 3) % 3 == 1) res = 1;
            else                           res = 2;
            blocked = (k == 0) && ((m_lw[k] == 1 && p == m_lm[k]) || (m_lw[k] == 2 && s == m_lm[k]));
            if (!blocked) begin
                m_manche[k] = res;
                m_mg[k]++;
                if (res == 1) begin m_pp[k]++; m_lw[k] = 1; m_lm[k] = p; end
                else if (res == 2) begin m_ps[k]++; m_lw[k] = 2; m_lm[k] = s; end
                else begin m_lw[k] = 0; m_lm[k] = 0; end
                lead = (m_pp[k] > m_ps[k]) ? m_pp[k] - m_ps[k] : m_ps[k] - m_pp[k];
                if (m_mg[k] == m_max[k] || (m_mg[k] >= MIN_M && lead >= VANT)) begin
                    m_partita[k] = (m_pp[k] > m_ps[k]) ? 1 : (m_pp[k] < m_ps[k]) ? 2 : 3;
                    m_phase[k] = 2;
                end
            end
        end
    endtask

    function automatic snap_t model_snap(input int k);
        snap_t e;
        e.manche = m_manche[k]; e.partita = m_partita[k];
        e.pp = m_pp[k]; e.ps = m_ps[k]; e.mg = m_mg[k];
        return e;
    endfunction

    task automatic chk(input int k, input string nm, input logic [7:0] act, input int exp);
        checks++;
        if (act !== 8'(exp)) begin
            failures++;
            $display("FAIL dut%0d %s: got %0d expected %0d at %0t", k, nm, act, exp, $time);
        end
    endtask

    task automatic chk_snap(input int k, input snap_t e, input logic [1:0] man, input logic [1:0] par,
                            input logic [W-1:0] pp, input logic [W-1:0] ps, input logic [W-1:0] mg);
        chk(k, "MANCHE", 8'(man), e.manche);
        chk(k, "PARTITA", 8'(par), e.partita);
        chk(k, "PUNTI_PRIMO", 8'(pp), e.pp);
        chk(k, "PUNTI_SECONDO", 8'(ps), e.ps);
        chk(k, "MANCHE_GIOCATE", 8'(mg), e.mg);
        $display("dut%0d manche=%0d partita=%0d p1=%0d p2=%0d giocate=%0d", k, man, par, pp, ps, mg);
    endtask

    // Monitor: one registered result per clock, compared just after the edge
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk_snap(0, e, bus0.MANCHE, bus0.PARTITA, bus0.PUNTI_PRIMO, bus0.PUNTI_SECONDO, bus0.MANCHE_GIOCATE);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk_snap(1, e, bus1.MANCHE, bus1.PARTITA, bus1.PUNTI_PRIMO, bus1.PUNTI_SECONDO, bus1.MANCHE_GIOCATE);
            end
        end
    end

    task automatic step(input bit ini, input int p, input int s);
        @(negedge clk);
        bus0.INIZIO = ini; bus0.PRIMO = 2'(p); bus0.SECONDO = 2'(s);
        bus1.INIZIO = ini; bus1.PRIMO = 2'(p); bus1.SECONDO = 2'(s);
        model_step(0, ini, p, s);
        model_step(1, ini, p, s);
        q0.push_back(model_snap(0));
        q1.push_back(model_snap(1));
    endtask

    task automatic check_reset_now();
        snap_t e;
        e = model_snap(0);
        chk_snap(0, e, bus0.MANCHE, bus0.PARTITA, bus0.PUNTI_PRIMO, bus0.PUNTI_SECONDO, bus0.MANCHE_GIOCATE);
        e = model_snap(1);
        chk_snap(1, e, bus1.MANCHE, bus1.PARTITA, bus1.PUNTI_PRIMO, bus1.PUNTI_SECONDO, bus1.MANCHE_GIOCATE);
    endtask

    // Asynchronous reset applied between edges, after the monitor has drained
    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_now();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus0.INIZIO = 1'b0; bus0.PRIMO = 2'b00; bus0.SECONDO = 2'b00;
        bus1.INIZIO = 1'b0; bus1.PRIMO = 2'b00; bus1.SECONDO = 2'b00;
        model_reset();
        #12;
        check_reset_now();
        @(negedge clk);
        rst_n = 1'b1;

        // Quick win by lead after a closing draw
        step(1, 0, 0);
        step(0, 1, 3); step(0, 2, 1); step(0, 3, 2); step(0, 2, 2);
        step(0, 1, 3); step(0, 0, 0);

        // Repeat of a winning move
        step(1, 0, 0);
        step(0, 2, 1); step(0, 2, 3); step(0, 0, 0);

        // Length limit reached at 2-2
        step(1, 1, 0);
        step(0, 1, 3); step(0, 2, 2); step(0, 1, 2); step(0, 2, 1); step(0, 1, 2);
        step(0, 0, 0);

        // Invalid moves mid-game
        step(1, 0, 0);
        step(0, 1, 3); step(0, 0, 2); step(0, 0, 2); step(0, 0, 2); step(0, 3, 3);

        // Maximum length, all draws, then ignored moves in FINE
        step(1, 3, 3);
        for (int i = 0; i < 19; i++) step(0, (i % 3) + 1, (i % 3) + 1);
        step(0, 1, 3); step(0, 2, 1);

        // Held setup: last value wins; setup beats valid moves
        step(1, 2, 2); step(1, 1, 0); step(1, 1, 3); step(0, 3, 1);

        // Reset mid-match, moves ignored until the next setup
        step(1, 0, 0);
        step(0, 1, 3); step(0, 2, 2); step(0, 3, 1);
        pulse_reset();
        step(0, 1, 3); step(0, 2, 1);
        step(1, 2, 0); step(0, 3, 2);

        // Randomized play with occasional setups and resets
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r == 0) pulse_reset();
            else step((r < 12) ? 1'b1 : 1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        @(posedge clk);
        #3;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d/%0d pending expected 0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/morra_cinese_param.md
# morra_cinese_param

Parametrised, fully registered rock-paper-scissors ("morra cinese") game engine. It configures a match length on a setup cycle, scores one manche per clock, and enforces the no-repeat-winning-move rule. It declares the match winner on either a length limit or a lead-margin limit and exposes live scores. It sits at the top of the game datapath, driven directly by the player input encoders.

## Interface
- MIN_MANCHE, 4: minimum number of counted manche before the lead rule can end the match; also the offset added to the setup value.
- VANTAGGIO, 2: lead, in manche won, that ends the match early once MIN_MANCHE are counted.
- CNT_W, 5: counter width; must satisfy 2^CNT_W > MIN_MANCHE+15.
- REGOLA_RIP, 1: 1 enables the no-repeat-winning-move rule; 0 disables it.
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- INIZIO  input  1  setup request; when sampled high, {SECONDO,PRIMO} is the configuration value.
- PRIMO  input  2  player 1 move: 00 none, 01 sasso, 10 carta, 11 forbice.
- SECONDO  input  2  player 2 move, same encoding.
- MANCHE  output  2  registered manche result: 00 invalid/none, 01 primo, 10 secondo, 11 pareggio.
- PARTITA  output  2  registered match result: 00 in progress/none, 01 primo, 10 secondo, 11 pareggio.
- PUNTI_PRIMO  output  CNT_W  manche won by player 1.
- PUNTI_SECONDO  output  CNT_W  manche won by player 2.
- MANCHE_GIOCATE  output  CNT_W  counted manche (wins plus draws).

## Operation
- States: IDLE (after reset), GIOCO, FINE.
- INIZIO=1 in any state is a setup cycle.
  - Load max = {SECONDO,PRIMO} + MIN_MANCHE (CNT_W-bit, zero-extended), giving a range of MIN_MANCHE..MIN_MANCHE+15.
  - Clear all counters and the last-winner record.
  - MANCHE<=00, PARTITA<=00, next state GIOCO.
  - INIZIO held high re-runs setup every cycle; the last sampled value wins.
- IDLE or FINE with INIZIO=0: inputs ignored, MANCHE<=00. Counters and PARTITA hold.
- GIOCO with INIZIO=0: each cycle is one manche attempt.
  - Either move 00: invalid. MANCHE<=00, no count, restriction record unchanged.
  - Rules: 01 beats 11, 10 beats 01, 11 beats 10. Equal moves are a draw (11).
  - Repeat rule (REGOLA_RIP=1): if the previous counted manche was won by player X with move M, and X plays M now, the manche is invalid. MANCHE<=00, no count.
  - A counted win stores {winner, move}; a counted draw clears the record.
  - A counted manche increments MANCHE_GIOCATE and the winner's counter (a draw increments only MANCHE_GIOCATE).
- End check uses the post-increment counts of the current manche:
  - If MANCHE_GIOCATE==max, or (MANCHE_GIOCATE>=MIN_MANCHE and |PUNTI_PRIMO-PUNTI_SECONDO|>=VANTAGGIO), the match ends.
  - PARTITA<=01 if PUNTI_PRIMO>PUNTI_SECONDO, 10 if lower, 11 if equal. Next state FINE.
- The lead difference is computed as an unsigned magnitude (larger minus smaller). There is no wrap; counters cannot exceed max.
- In FINE, PARTITA and all counters hold until the next setup or reset.

## Timing
- Reset (rst_n low, asynchronous): state IDLE; MANCHE=00, PARTITA=00; all counters 0; max=MIN_MANCHE; restriction record cleared. Reset asserted mid-match aborts it immediately.
- Latency is 1 cycle: inputs sampled at edge k appear on MANCHE, counters and PARTITA after edge k.
- The final manche's MANCHE value and the nonzero PARTITA value become visible on the same cycle.
- MANCHE is valid for exactly one cycle per attempt. It returns to 00 in the following cycle unless a new attempt occurs.
- Simultaneous INIZIO=1 with valid moves: setup has priority; the moves are not scored.
- No combinational path from inputs to outputs.

## Test plan
- Reset then setup with {SECONDO,PRIMO}=0000 (max=4); play primo 01 vs 11, then 10 vs 01 -> MANCHE 01, 01; PUNTI_PRIMO=2. Next, 11 vs 10 -> 01; PUNTI_PRIMO=3, MANCHE_GIOCATE=3, PARTITA=00. Then draw 10/10 -> MANCHE=11; MANCHE_GIOCATE=4, lead 3 -> PARTITA=01; state FINE.
- Repeat rule: primo wins with 10 vs 01, then plays 10 again vs 11 -> MANCHE=00; counters unchanged. With REGOLA_RIP=0 the same stimulus gives MANCHE=10 and PUNTI_SECONDO=1.
- Setup 0001 (max=5), alternating wins and draws ending 2-2 with 1 draw -> at MANCHE_GIOCATE=5, PARTITA=11.
- Invalid moves: PRIMO=00 for 3 cycles mid-game -> MANCHE=00 each cycle; MANCHE_GIOCATE unchanged; PARTITA=00.
- Setup 1111 (max=19), 19 draws -> PARTITA=11 only on the 19th; moves in FINE are ignored and PARTITA holds.
- rst_n pulsed low mid-match (after 3 manche) -> all outputs 0 asynchronously, state IDLE; moves are ignored until INIZIO.
